// File: rtl/video_dnn_result_overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_dnn_result_overlay_pkg
// Purpose  : Shared constants for the DNN result display path: default class
//            count, the statistics FSM state encoding, and the per-class
//            RGB888 overlay colour table.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package video_dnn_result_overlay_pkg;

  localparam int c_NUM_CLASS_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } stat_state_e;

  // Class colour table, RGB888 with R in the MSBs. Classes outside the
  // table map to black; they are never blended because detection requires
  // a valid class number.
  function automatic logic [23:0] class_color(input int unsigned idx);
    logic [23:0] w_c;
    case (idx)
      0:       w_c = 24'hFF0000;
      1:       w_c = 24'hFF8000;
      2:       w_c = 24'h00FF00;
      3:       w_c = 24'hFFFF00;
      4:       w_c = 24'h0000FF;
      5:       w_c = 24'hFF00FF;
      6:       w_c = 24'h00FFFF;
      7:       w_c = 24'h800080;
      8:       w_c = 24'h808080;
      9:       w_c = 24'hFFFFFF;
      default: w_c = 24'h000000;
    endcase
    return w_c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_dnn_result_overlay_class_stat.sv
`default_nettype none
// ============================================================================
// Module   : video_dnn_class_stat
// Purpose  : Per-frame, per-class detection counters. On each start-of-frame
//            the counters are snapshotted and cleared, then the snapshot is
//            scanned one class per cycle to find the winning class.
// Ports    : clk/rst_n        clock, asynchronous active-low reset
//            i_beat           accepted input beat
//            i_sof            start-of-frame flag of the beat
//            i_hit            beat carries a valid class over threshold
//            i_number         class number of the beat
//            o_stat_counts    snapshot of the previous frame, class 0 in LSBs
//            o_max_number     winning class (lowest number on ties)
//            o_max_count      winning class's count
//            o_valid          one-cycle pulse when the stat outputs update
//            o_drop           wrapping count of scans restarted by early SOF
// Revision : 1.0 - initial release
// ============================================================================
module video_dnn_class_stat
  import video_dnn_result_overlay_pkg::*;
#(
  parameter int NUM_CLASS     = c_NUM_CLASS_DEFAULT,
  parameter int TNUMBER_WIDTH = 4,
  parameter int STAT_WIDTH    = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_beat,
  input  logic                            i_sof,
  input  logic                            i_hit,
  input  logic [TNUMBER_WIDTH-1:0]        i_number,
  output logic [NUM_CLASS*STAT_WIDTH-1:0] o_stat_counts,
  output logic [TNUMBER_WIDTH-1:0]        o_max_number,
  output logic [STAT_WIDTH-1:0]           o_max_count,
  output logic                            o_valid,
  output logic [7:0]                      o_drop
);

  localparam logic [STAT_WIDTH-1:0]    c_SAT      = '1;
  localparam logic [TNUMBER_WIDTH-1:0] c_LAST_IDX = TNUMBER_WIDTH'(NUM_CLASS - 1);

  stat_state_e                     r_state;
  stat_state_e                     w_state_nx;
  logic [STAT_WIDTH-1:0]           r_cnt  [NUM_CLASS];
  logic [STAT_WIDTH-1:0]           r_snap [NUM_CLASS];
  logic                            r_frame_started;
  logic [TNUMBER_WIDTH-1:0]        r_idx;
  logic [TNUMBER_WIDTH-1:0]        r_best_num;
  logic [STAT_WIDTH-1:0]           r_best_cnt;
  logic [NUM_CLASS*STAT_WIDTH-1:0] r_stat_counts;
  logic [TNUMBER_WIDTH-1:0]        r_max_number;
  logic [STAT_WIDTH-1:0]           r_max_count;
  logic                            r_valid;
  logic [7:0]                      r_drop;
  logic                            w_hit;
  logic                            w_latch;

  assign w_hit   = i_beat && i_hit;
  // The very first SOF after reset only arms the frame tracking.
  assign w_latch = i_beat && i_sof && r_frame_started;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_latch) begin
      // A new snapshot always (re)starts the scan, even mid-scan.
      w_state_nx = ST_SCAN;
    end else begin
      case (r_state)
        ST_SCAN: if (r_idx == c_LAST_IDX) w_state_nx = ST_DONE;
        ST_DONE: w_state_nx = ST_IDLE;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        r_cnt[i]  <= '0;
        r_snap[i] <= '0;
      end
      r_frame_started <= 1'b0;
      r_idx           <= '0;
      r_best_num      <= '0;
      r_best_cnt      <= '0;
      r_stat_counts   <= '0;
      r_max_number    <= '0;
      r_max_count     <= '0;
      r_valid         <= 1'b0;
      r_drop          <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_beat && i_sof) r_frame_started <= 1'b1;

      // The SOF pixel belongs to the new frame, so it seeds the cleared counter.
      for (int i = 0; i < NUM_CLASS; i++) begin
        if (w_latch) begin
          r_snap[i] <= r_cnt[i];
          r_cnt[i]  <= (w_hit && i_number == TNUMBER_WIDTH'(i)) ? STAT_WIDTH'(1) : '0;
        end else if (w_hit && i_number == TNUMBER_WIDTH'(i) && r_cnt[i] != c_SAT) begin
          r_cnt[i] <= r_cnt[i] + STAT_WIDTH'(1);
        end
      end

      if (w_latch) begin
        // Class 0 seeds the winner straight from the live counter, which is
        // exactly what lands in snapshot[0] on this edge.
        r_idx      <= TNUMBER_WIDTH'(1);
        r_best_num <= '0;
        r_best_cnt <= r_cnt[0];
        if (r_state != ST_IDLE) r_drop <= r_drop + 8'd1;
      end else if (r_state == ST_SCAN) begin
        // Strictly greater keeps the lowest class number on ties.
        if (r_snap[r_idx] > r_best_cnt) begin
          r_best_cnt <= r_snap[r_idx];
          r_best_num <= r_idx;
        end
        r_idx <= r_idx + TNUMBER_WIDTH'(1);
      end else if (r_state == ST_DONE) begin
        r_valid      <= 1'b1;
        r_max_number <= r_best_num;
        r_max_count  <= r_best_cnt;
        for (int i = 0; i < NUM_CLASS; i++) begin
          r_stat_counts[i*STAT_WIDTH +: STAT_WIDTH] <= r_snap[i];
        end
      end
    end
  end

  assign o_stat_counts = r_stat_counts;
  assign o_max_number  = r_max_number;
  assign o_max_count   = r_max_count;
  assign o_valid       = r_valid;
  assign o_drop        = r_drop;

endmodule
`default_nettype wire

// File: rtl/video_dnn_result_overlay.sv
`default_nettype none
// ============================================================================
// Module   : video_dnn_result_overlay
// Purpose  : Renders per-pixel classification results as RGB video. Detected
//            pixels are averaged with their class colour, others pass through
//            as grey. Also reports per-frame class statistics.
// Ports    : aresetn/aclk       asynchronous active-low reset, clock
//            param_enable       overlay enable (statistics always run)
//            param_count_th     minimum vote count for a detection
//            s_axi4s_*          classifier stream in (tuser[0] = SOF)
//            m_axi4s_*          RGB stream out, R in the MSBs
//            stat_*             previous-frame statistics and drop counter
// Revision : 1.0 - initial release
// ============================================================================
module video_dnn_result_overlay
  import video_dnn_result_overlay_pkg::*;
#(
  parameter int NUM_CLASS     = c_NUM_CLASS_DEFAULT,
  parameter int TUSER_WIDTH   = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int STAT_WIDTH    = 20
) (
  input  logic                            aresetn,
  input  logic                            aclk,
  input  logic                            param_enable,
  input  logic [TCOUNT_WIDTH-1:0]         param_count_th,
  input  logic [TUSER_WIDTH-1:0]          s_axi4s_tuser,
  input  logic                            s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0]        s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]         s_axi4s_tcount,
  input  logic [DATA_WIDTH-1:0]           s_axi4s_tdata,
  input  logic                            s_axi4s_tvalid,
  output logic                            s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]          m_axi4s_tuser,
  output logic                            m_axi4s_tlast,
  output logic [3*DATA_WIDTH-1:0]         m_axi4s_tdata,
  output logic                            m_axi4s_tvalid,
  input  logic                            m_axi4s_tready,
  output logic [NUM_CLASS*STAT_WIDTH-1:0] stat_counts,
  output logic [TNUMBER_WIDTH-1:0]        stat_max_number,
  output logic [STAT_WIDTH-1:0]           stat_max_count,
  output logic                            stat_valid,
  output logic [7:0]                      stat_drop
);

  // One extra bit so NUM_CLASS = 2**TNUMBER_WIDTH still compares correctly.
  localparam logic [TNUMBER_WIDTH:0] c_NUM_CLASS_EXT = (TNUMBER_WIDTH + 1)'(NUM_CLASS);

  logic                    w_cke;
  logic                    w_accept;
  logic                    w_hit;
  logic                    w_det;
  logic [23:0]             w_color888;
  logic [3*DATA_WIDTH-1:0] w_color;
  logic [3*DATA_WIDTH-1:0] w_blend;

  logic                    r_s1_valid;
  logic [TUSER_WIDTH-1:0]  r_s1_user;
  logic                    r_s1_last;
  logic                    r_s1_det;
  logic [DATA_WIDTH-1:0]   r_s1_pix;
  logic [3*DATA_WIDTH-1:0] r_s1_color;

  logic                    r_m_tvalid;
  logic [TUSER_WIDTH-1:0]  r_m_tuser;
  logic                    r_m_tlast;
  logic [3*DATA_WIDTH-1:0] r_m_tdata;

  // Both stages advance together whenever the output register can move.
  assign w_cke          = !r_m_tvalid || m_axi4s_tready;
  assign s_axi4s_tready = w_cke;
  assign w_accept       = s_axi4s_tvalid && w_cke;

  // Statistics count threshold hits regardless of the overlay enable.
  assign w_hit = ({1'b0, s_axi4s_tnumber} < c_NUM_CLASS_EXT) &&
                 (s_axi4s_tcount >= param_count_th);
  assign w_det = param_enable && w_hit;

  assign w_color888 = class_color(32'(s_axi4s_tnumber));
  assign w_color    = {DATA_WIDTH'(w_color888[23:16]),
                       DATA_WIDTH'(w_color888[15:8]),
                       DATA_WIDTH'(w_color888[7:0])};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_valid <= 1'b0;
      r_s1_user  <= '0;
      r_s1_last  <= 1'b0;
      r_s1_det   <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_color <= '0;
    end else if (w_cke) begin
      r_s1_valid <= s_axi4s_tvalid;
      r_s1_user  <= s_axi4s_tuser;
      r_s1_last  <= s_axi4s_tlast;
      r_s1_det   <= w_det;
      r_s1_pix   <= s_axi4s_tdata;
      r_s1_color <= w_color;
    end
  end

  // Average at DATA_WIDTH+1 bits; the halved sum always fits DATA_WIDTH.
  for (genvar g = 0; g < 3; g++) begin : g_blend
    logic [DATA_WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_s1_color[g*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, r_s1_pix};
    assign w_blend[g*DATA_WIDTH +: DATA_WIDTH] =
      r_s1_det ? DATA_WIDTH'(w_sum >> 1) : r_s1_pix;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
    end else if (w_cke) begin
      r_m_tvalid <= r_s1_valid;
      r_m_tuser  <= r_s1_user;
      r_m_tlast  <= r_s1_last;
      r_m_tdata  <= w_blend;
    end
  end

  assign m_axi4s_tvalid = r_m_tvalid;
  assign m_axi4s_tuser  = r_m_tuser;
  assign m_axi4s_tlast  = r_m_tlast;
  assign m_axi4s_tdata  = r_m_tdata;

  video_dnn_class_stat #(
    .NUM_CLASS     (NUM_CLASS),
    .TNUMBER_WIDTH (TNUMBER_WIDTH),
    .STAT_WIDTH    (STAT_WIDTH)
  ) u_class_stat (
    .clk           (aclk),
    .rst_n         (aresetn),
    .i_beat        (w_accept),
    .i_sof         (s_axi4s_tuser[0]),
    .i_hit         (w_hit),
    .i_number      (s_axi4s_tnumber),
    .o_stat_counts (stat_counts),
    .o_max_number  (stat_max_number),
    .o_max_count   (stat_max_count),
    .o_valid       (stat_valid),
    .o_drop        (stat_drop)
  );

endmodule
`default_nettype wire

// File: tb/tb_video_dnn_result_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_dnn_result_overlay
// Purpose  : Directed self-checking bench for video_dnn_result_overlay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_dnn_result_overlay;

  localparam int NC = 10;
  localparam int UW = 1;
  localparam int NW = 4;
  localparam int CW = 4;
  localparam int DW = 8;
  localparam int SW = 4;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              param_enable = 1'b1;
  logic [CW-1:0]     param_count_th = 4'd3;
  logic [UW-1:0]     s_axi4s_tuser = '0;
  logic              s_axi4s_tlast = 1'b0;
  logic [NW-1:0]     s_axi4s_tnumber = 4'd15;
  logic [CW-1:0]     s_axi4s_tcount = '0;
  logic [DW-1:0]     s_axi4s_tdata = '0;
  logic              s_axi4s_tvalid = 1'b0;
  logic              s_axi4s_tready;
  logic [UW-1:0]     m_axi4s_tuser;
  logic              m_axi4s_tlast;
  logic [3*DW-1:0]   m_axi4s_tdata;
  logic              m_axi4s_tvalid;
  logic              m_axi4s_tready = 1'b1;
  logic [NC*SW-1:0]  stat_counts;
  logic [NW-1:0]     stat_max_number;
  logic [SW-1:0]     stat_max_count;
  logic              stat_valid;
  logic [7:0]        stat_drop;

  int n_vec = 0;
  int n_err = 0;
  int pulses, first, sent, got;
  logic [7:0] e8;

  // Overlay vectors: pix, class, votes, enable -> expected RGB (hand-computed)
  logic [7:0]  ov_pix [9] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h40, 8'h40, 8'h10, 8'hFF, 8'h00};
  logic [3:0]  ov_num [9] = '{4'd2, 4'd2, 4'd2, 4'd0, 4'd2, 4'd15, 4'd9, 4'd9, 4'd4};
  logic [3:0]  ov_cnt [9] = '{4'd5, 4'd2, 4'd3, 4'd9, 4'd5, 4'd15, 4'd4, 4'd15, 4'd3};
  logic        ov_en  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [23:0] ov_exp [9] = '{24'h209F20, 24'h404040, 24'h209F20, 24'hBF4040, 24'h404040,
                              24'h404040, 24'h878787, 24'hFFFFFF, 24'h00007F};

  video_dnn_result_overlay #(
    .NUM_CLASS(NC), .TUSER_WIDTH(UW), .TNUMBER_WIDTH(NW),
    .TCOUNT_WIDTH(CW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)
  ) dut (
    .aresetn(aresetn), .aclk(aclk),
    .param_enable(param_enable), .param_count_th(param_count_th),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tnumber(s_axi4s_tnumber), .s_axi4s_tcount(s_axi4s_tcount),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
    .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready),
    .stat_counts(stat_counts), .stat_max_number(stat_max_number),
    .stat_max_count(stat_max_count), .stat_valid(stat_valid),
    .stat_drop(stat_drop)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_in();
    s_axi4s_tvalid  = 1'b0;
    s_axi4s_tuser   = '0;
    s_axi4s_tlast   = 1'b0;
    s_axi4s_tnumber = 4'd15;
    s_axi4s_tcount  = '0;
    s_axi4s_tdata   = '0;
  endtask

  task automatic beat(input logic sof, input logic last, input logic [3:0] num,
                      input logic [3:0] cnt, input logic [7:0] pix);
    s_axi4s_tvalid  = 1'b1;
    s_axi4s_tuser   = sof;
    s_axi4s_tlast   = last;
    s_axi4s_tnumber = num;
    s_axi4s_tcount  = cnt;
    s_axi4s_tdata   = pix;
  endtask

  // SOF beat accepted on edge 0; counts stat_valid pulses over the next 14 edges.
  task automatic sof_and_wait(output int np, output int fc);
    beat(1'b1, 1'b0, 4'd15, 4'd0, 8'h00);
    tick();
    idle_in();
    np = 0;
    fc = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (stat_valid) begin
        np++;
        if (fc < 0) fc = k;
      end
    end
  endtask

  initial begin
    // ---- reset state ----
    idle_in();
    tick(); tick();
    chk("rst_tvalid", m_axi4s_tvalid, 0);
    chk("rst_tdata", m_axi4s_tdata, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_stat_counts", stat_counts, 0);
    chk("rst_stat_drop", stat_drop, 0);
    aresetn = 1'b1;
    tick();
    chk("idle_tready", s_axi4s_tready, 1);

    // ---- overlay, latency 2, back-to-back beats ----
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin
        param_enable = ov_en[i];
        beat(1'b0, 1'b0, ov_num[i], ov_cnt[i], ov_pix[i]);
      end else begin
        idle_in();
      end
      tick();
      if (i >= 1) begin
        chk("ov_tvalid", m_axi4s_tvalid, 1);
        chk("ov_tdata", m_axi4s_tdata, ov_exp[i-1]);
      end
    end
    param_enable = 1'b1;
    tick();
    chk("ov_drain_tvalid", m_axi4s_tvalid, 0);

    // ---- backpressure over a 4x3 grey frame ----
    aresetn = 1'b0; tick(); aresetn = 1'b1; tick();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      m_axi4s_tready = !(cyc >= 5 && cyc < 12);
      if (sent < 12) beat(sent == 0, (sent % 4) == 3, 4'd15, 4'd0, 8'(sent * 16 + 1));
      else idle_in();
      #1;
      if (m_axi4s_tvalid) begin
        e8 = 8'(got * 16 + 1);
        chk("bp_tdata", m_axi4s_tdata, {3{e8}});
        chk("bp_tuser", m_axi4s_tuser, (got == 0) ? 1 : 0);
        chk("bp_tlast", m_axi4s_tlast, ((got % 4) == 3) ? 1 : 0);
        if (!m_axi4s_tready) chk("bp_stall_tready", s_axi4s_tready, 0);
        else got++;
      end
      if (s_axi4s_tvalid && s_axi4s_tready) sent++;
      @(posedge aclk);
      #1;
    end
    chk("bp_beats_out", got, 12);
    m_axi4s_tready = 1'b1;
    idle_in();

    // ---- statistics: first SOF silent, second reports tie-broken winner ----
    aresetn = 1'b0; tick(); aresetn = 1'b1; tick();
    sof_and_wait(pulses, first);
    chk("first_sof_no_valid", pulses, 0);
    for (int i = 0; i < 11; i++) begin
      if (i < 5)       beat(1'b0, 1'b0, 4'd7, 4'd5, 8'h11);
      else if (i < 10) beat(1'b0, 1'b0, 4'd3, 4'd4, 8'h22);
      else             beat(1'b0, 1'b0, 4'd15, 4'd9, 8'h33);
      tick();
    end
    sof_and_wait(pulses, first);
    chk("stat_pulses", pulses, 1);
    chk("stat_latency", first, 10);
    chk("stat_counts", stat_counts, 40'h0050005000);
    chk("stat_max_number", stat_max_number, 3);
    chk("stat_max_count", stat_max_count, 5);
    chk("stat_drop_none", stat_drop, 0);

    // ---- early SOF: second SOF four cycles later restarts the scan ----
    beat(1'b0, 1'b0, 4'd5, 4'd9, 8'h00);
    tick();
    pulses = 0;
    first  = -1;
    for (int k = 0; k <= 20; k++) begin
      case (k)
        0, 4:    beat(1'b1, 1'b0, 4'd15, 4'd0, 8'h00);
        1, 2:    beat(1'b0, 1'b0, 4'd6, 4'd9, 8'h00);
        default: idle_in();
      endcase
      tick();
      if (k == 13) chk("early_held_max", stat_max_number, 3);
      if (stat_valid) begin
        pulses++;
        first = k;
      end
    end
    chk("early_pulses", pulses, 1);
    chk("early_latency", first, 14);
    chk("early_drop", stat_drop, 1);
    chk("early_counts", stat_counts, 40'h0002000000);
    chk("early_max_number", stat_max_number, 6);
    chk("early_max_count", stat_max_count, 2);

    // ---- saturation: 20 detections with 4-bit counters ----
    for (int i = 0; i < 20; i++) begin
      beat(1'b0, 1'b0, 4'd1, 4'd9, 8'h55);
      tick();
    end
    sof_and_wait(pulses, first);
    chk("sat_pulses", pulses, 1);
    chk("sat_counts", stat_counts, 40'h00000000F0);
    chk("sat_max_number", stat_max_number, 1);
    chk("sat_max_count", stat_max_count, 15);

    // ---- reset mid-frame ----
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b0, 4'd2, 4'd9, 8'h40);
      tick();
    end
    aresetn = 1'b0;
    #2;
    chk("mrst_tvalid", m_axi4s_tvalid, 0);
    chk("mrst_tdata", m_axi4s_tdata, 0);
    chk("mrst_counts", stat_counts, 0);
    chk("mrst_max_number", stat_max_number, 0);
    chk("mrst_max_count", stat_max_count, 0);
    chk("mrst_drop", stat_drop, 0);
    idle_in();
    tick();
    aresetn = 1'b1;
    tick();
    sof_and_wait(pulses, first);
    chk("mrst_first_sof_no_valid", pulses, 0);
    sof_and_wait(pulses, first);
    chk("zero_frame_pulses", pulses, 1);
    chk("zero_frame_latency", first, 10);
    chk("zero_frame_max_number", stat_max_number, 0);
    chk("zero_frame_max_count", stat_max_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
